// File: rtl/fish_pkg.sv
// fish_pkg -- shared definitions for the fish catching game controller:
// FSM state encoding, reel-nibble thresholds, escape limit and small helpers.
package fish_pkg;

    // Game FSM states; the numeric value is what appears on the state output.
    typedef enum logic [1:0] {
        ST_FISH  = 2'd0,
        ST_CATCH = 2'd1,
        ST_WIN   = 2'd2
    } fish_state_e;

    // Reel nibble at or below this value produces no pull.
    localparam logic [3:0] REEL_IDLE_MAX_N = 4'd8;
    // Reel nibble equal to this value produces a single-step pull.
    localparam logic [3:0] REEL_SLOW_N     = 4'd9;
    // Number of consecutive idle CATCH ticks after which the fish escapes.
    localparam logic [6:0] ESCAPE_LIMIT    = 7'd64;

    // Fish depth for a level: base - lvl*step, truncated to the 10-bit pixel range.
    function automatic logic [9:0] depth_of(input int base, input int step, input logic [2:0] lvl);
        int d;
        d = base - int'({29'd0, lvl}) * step;
        return d[9:0];
    endfunction

    // Upward pull for one CATCH tick, selected by the top nibble of the reel sensor.
    function automatic logic [9:0] reel_pull(input logic [3:0] n, input logic [9:0] step);
        logic [9:0] p;
        if (n <= REEL_IDLE_MAX_N) begin
            p = 10'd0;
        end else if (n == REEL_SLOW_N) begin
            p = step;
        end else begin
            p = {step[8:0], 1'b0};
        end
        return p;
    endfunction

endpackage

// File: rtl/fish_catch_ctrl_if.sv
// fish_catch_ctrl_if -- player inputs and display outputs of the fish
// catching controller. The game side (master) drives buttons/reel, the
// controller (slave) drives positions, level, state, win and score.
interface fish_catch_ctrl_if #(
    parameter int REEL_W = 9
);
    logic              tick;
    logic              left;
    logic              right;
    logic              grab;
    logic [REEL_W-1:0] reel;
    logic [9:0]        hook_x;
    logic [9:0]        hook_y;
    logic [9:0]        fish_x;
    logic [9:0]        fish_y;
    logic [2:0]        level;
    logic [1:0]        state;
    logic              win;
    logic [7:0]        score;

    modport master (
        output tick, left, right, grab, reel,
        input  hook_x, hook_y, fish_x, fish_y, level, state, win, score
    );

    modport slave (
        input  tick, left, right, grab, reel,
        output hook_x, hook_y, fish_x, fish_y, level, state, win, score
    );
endinterface

// File: rtl/fish_hit_detect.sv
// fish_hit_detect -- combinational catch test. The window shrinks with the
// level (halved per level, never below one pixel); the hook must lie
// horizontally within [fish_x, fish_x+width] and vertically within +/-height.
module fish_hit_detect #(
    parameter int HIT_W = 16,
    parameter int HIT_H = 10
) (
    input  logic [2:0] i_level,
    input  logic [9:0] i_fish_x,
    input  logic [9:0] i_fish_y,
    input  logic [9:0] i_hook_x,
    input  logic [9:0] i_hook_y,
    output logic       o_hit
);
    logic [9:0]  w_win_w;
    logic [9:0]  w_win_h;
    logic [9:0]  w_dy;
    logic [10:0] w_x_hi;

    // Level-scaled window size, clamped to at least one pixel each way.
    always_comb begin
        w_win_w = 10'(HIT_W) >> i_level;
        w_win_h = 10'(HIT_H) >> i_level;
        if (w_win_w == 10'd0) begin
            w_win_w = 10'd1;
        end else begin
            w_win_w = w_win_w;
        end
        if (w_win_h == 10'd0) begin
            w_win_h = 10'd1;
        end else begin
            w_win_h = w_win_h;
        end
    end

    // Hook-versus-fish distance test; right edge computed one bit wider to avoid wrap.
    always_comb begin
        w_x_hi = {1'b0, i_fish_x} + {1'b0, w_win_w};
        if (i_hook_y >= i_fish_y) begin
            w_dy = i_hook_y - i_fish_y;
        end else begin
            w_dy = i_fish_y - i_hook_y;
        end
        o_hit = (i_fish_x <= i_hook_x) && ({1'b0, i_hook_x} <= w_x_hi) && (w_dy <= w_win_h);
    end
endmodule

// File: rtl/fish_catch_ctrl.sv
// fish_catch_ctrl -- fishing game controller. In FISH the fish swims left and
// wraps, the hook sinks to the fish depth and the rod moves with left/right;
// a grab inside the hit window enters CATCH, where the reel sensor pulls the
// hooked fish up until it breaks the surface. Landing the last fish enters WIN.
// Optional feature: define FISH_ESCAPE_EN to let a fish escape after 64
// consecutive CATCH ticks without any pull.
module fish_catch_ctrl
    import fish_pkg::*;
#(
    parameter int NUM_LEVELS = 4,
    parameter int LEFT_X     = 144,
    parameter int RIGHT_X    = 798,
    parameter int SURFACE_Y  = 106,
    parameter int DEPTH0     = 470,
    parameter int DEPTH_STEP = 90,
    parameter int FISH_SPEED = 2,
    parameter int SINK_STEP  = 4,
    parameter int ROD_STEP   = 3,
    parameter int REEL_STEP  = 2,
    parameter int HIT_W      = 16,
    parameter int HIT_H      = 10,
    parameter int REEL_W     = 9
) (
    input  logic          clk,
    input  logic          rst,
    fish_catch_ctrl_if.slave bus
);
    localparam logic [9:0] L_LEFT    = 10'(LEFT_X);
    localparam logic [9:0] L_RIGHT   = 10'(RIGHT_X);
    localparam logic [9:0] L_SURFACE = 10'(SURFACE_Y);
    localparam logic [9:0] L_DEPTH0  = 10'(DEPTH0);
    localparam logic [9:0] L_WRAP    = 10'(LEFT_X + FISH_SPEED);
    localparam logic [9:0] L_FSPEED  = 10'(FISH_SPEED);
    localparam logic [9:0] L_SINK    = 10'(SINK_STEP);
    localparam logic [9:0] L_ROD     = 10'(ROD_STEP);
    localparam logic [9:0] L_REEL    = 10'(REEL_STEP);
    localparam logic [9:0] L_HOOK_X0 = 10'd450;
    localparam logic [2:0] L_LAST    = 3'(NUM_LEVELS - 1);

    fish_state_e r_state;
    logic [2:0]  r_level;
    logic [7:0]  r_score;
    logic [9:0]  r_hook_x;
    logic [9:0]  r_hook_y;
    logic [9:0]  r_fish_x;
    logic [9:0]  r_fish_y;
    logic        r_win;

    logic        w_hit;
    logic        w_landed;
    logic        w_last;
    logic        w_escape;
    logic [3:0]  w_nib;
    logic [9:0]  w_pull;
    logic [9:0]  w_depth_cur;
    logic [9:0]  w_depth_next;
    logic [9:0]  w_fish_x_swim;
    logic [10:0] w_hy_plus;
    logic [9:0]  w_hook_y_sink;
    logic [10:0] w_hx_plus;
    logic [9:0]  w_hook_x_right;
    logic [9:0]  w_hook_x_left;
    logic [9:0]  w_fish_y_pull;
    logic [9:0]  w_hook_y_pull;
    logic [7:0]  w_score_inc;

    fish_hit_detect #(
        .HIT_W (HIT_W),
        .HIT_H (HIT_H)
    ) u_hit (
        .i_level  (r_level),
        .i_fish_x (r_fish_x),
        .i_fish_y (r_fish_y),
        .i_hook_x (r_hook_x),
        .i_hook_y (r_hook_y),
        .o_hit    (w_hit)
    );

    // Candidate next values for every move the FSM may select this tick.
    always_comb begin
        w_nib         = bus.reel[REEL_W-1 -: 4];
        w_pull        = reel_pull(w_nib, L_REEL);
        w_depth_cur   = depth_of(DEPTH0, DEPTH_STEP, r_level);
        w_depth_next  = depth_of(DEPTH0, DEPTH_STEP, r_level + 3'd1);
        w_landed      = (r_fish_y < L_SURFACE);
        w_last        = (r_level == L_LAST);
        w_score_inc   = (r_score == 8'hFF) ? 8'hFF : (r_score + 8'd1);

        if (r_fish_x < L_WRAP) begin
            w_fish_x_swim = L_RIGHT;
        end else begin
            w_fish_x_swim = r_fish_x - L_FSPEED;
        end

        w_hy_plus = {1'b0, r_hook_y} + {1'b0, L_SINK};
        if (w_hy_plus >= {1'b0, w_depth_cur}) begin
            w_hook_y_sink = w_depth_cur;
        end else begin
            w_hook_y_sink = w_hy_plus[9:0];
        end

        w_hx_plus = {1'b0, r_hook_x} + {1'b0, L_ROD};
        if (w_hx_plus > {1'b0, L_RIGHT}) begin
            w_hook_x_right = L_RIGHT;
        end else begin
            w_hook_x_right = w_hx_plus[9:0];
        end
        if (r_hook_x < (L_LEFT + L_ROD)) begin
            w_hook_x_left = L_LEFT;
        end else begin
            w_hook_x_left = r_hook_x - L_ROD;
        end

        if (r_fish_y < w_pull) begin
            w_fish_y_pull = 10'd0;
        end else begin
            w_fish_y_pull = r_fish_y - w_pull;
        end
        if (r_hook_y < w_pull) begin
            w_hook_y_pull = 10'd0;
        end else begin
            w_hook_y_pull = r_hook_y - w_pull;
        end
    end

`ifdef FISH_ESCAPE_EN
    logic [6:0] r_slack;

    // Escape fires on the idle CATCH tick that brings the slack count to the limit.
    always_comb begin
        if ((r_state == ST_CATCH) && (w_pull == 10'd0) && ((r_slack + 7'd1) == ESCAPE_LIMIT)) begin
            w_escape = 1'b1;
        end else begin
            w_escape = 1'b0;
        end
    end

    // Slack counter: counts idle CATCH ticks, cleared by any pull and outside CATCH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slack <= 7'd0;
        end else if (bus.tick) begin
            if ((r_state == ST_CATCH) && !w_landed && (w_pull == 10'd0) && !w_escape) begin
                r_slack <= r_slack + 7'd1;
            end else begin
                r_slack <= 7'd0;
            end
        end
    end
`else
    assign w_escape = 1'b0;
`endif

    // Game FSM with all position, level, score and win registers; only advances on tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_FISH;
            r_level  <= 3'd0;
            r_score  <= 8'd0;
            r_hook_x <= L_HOOK_X0;
            r_hook_y <= L_SURFACE;
            r_fish_x <= L_RIGHT;
            r_fish_y <= L_DEPTH0;
            r_win    <= 1'b0;
        end else if (bus.tick) begin
            case (r_state)
                ST_FISH: begin
                    r_win <= 1'b0;
                    if (bus.grab && w_hit) begin
                        r_state <= ST_CATCH;
                    end else begin
                        r_fish_x <= w_fish_x_swim;
                        r_fish_y <= w_depth_cur;
                        r_hook_y <= w_hook_y_sink;
                        if (bus.right) begin
                            r_hook_x <= w_hook_x_right;
                        end else if (bus.left) begin
                            r_hook_x <= w_hook_x_left;
                        end
                    end
                end
                ST_CATCH: begin
                    if (w_landed) begin
                        r_score <= w_score_inc;
                        if (w_last) begin
                            r_state <= ST_WIN;
                            r_win   <= 1'b1;
                        end else begin
                            r_state  <= ST_FISH;
                            r_level  <= r_level + 3'd1;
                            r_fish_x <= L_RIGHT;
                            r_fish_y <= w_depth_next;
                        end
                    end else if (w_escape) begin
                        r_state  <= ST_FISH;
                        r_fish_x <= L_RIGHT;
                        r_fish_y <= w_depth_cur;
                    end else begin
                        r_fish_x <= r_hook_x;
                        r_fish_y <= w_fish_y_pull;
                        r_hook_y <= w_hook_y_pull;
                    end
                end
                ST_WIN: begin
                    if (bus.left || bus.right) begin
                        r_state  <= ST_FISH;
                        r_win    <= 1'b0;
                        r_level  <= 3'd0;
                        r_score  <= 8'd0;
                        r_fish_x <= L_RIGHT;
                        r_fish_y <= L_DEPTH0;
                        r_hook_y <= L_SURFACE;
                    end
                end
                default: begin
                    r_state <= ST_FISH;
                    r_win   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.hook_x = r_hook_x;
    assign bus.hook_y = r_hook_y;
    assign bus.fish_x = r_fish_x;
    assign bus.fish_y = r_fish_y;
    assign bus.level  = r_level;
    assign bus.state  = r_state;
    assign bus.win    = r_win;
    assign bus.score  = r_score;
endmodule

// File: tb/tb_fish_catch_ctrl.sv
// tb_fish_catch_ctrl -- self-checking bench for fish_catch_ctrl: a reset
// vector table, directed game sequences and randomized play checked against
// an integer reference model of the game rules.
module tb_fish_catch_ctrl;
    import fish_pkg::*;

    localparam int NUM_LEVELS = 4;
    localparam int LEFT_X     = 144;
    localparam int RIGHT_X    = 798;
    localparam int SURFACE_Y  = 106;
    localparam int DEPTH0     = 470;
    localparam int DEPTH_STEP = 90;
    localparam int FISH_SPEED = 2;
    localparam int SINK_STEP  = 4;
    localparam int ROD_STEP   = 3;
    localparam int REEL_STEP  = 2;
    localparam int HIT_W      = 16;
    localparam int HIT_H      = 10;
    localparam int REEL_W     = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    fish_catch_ctrl_if #(.REEL_W(REEL_W)) bus ();

    fish_catch_ctrl #(
        .NUM_LEVELS(NUM_LEVELS), .LEFT_X(LEFT_X), .RIGHT_X(RIGHT_X), .SURFACE_Y(SURFACE_Y),
        .DEPTH0(DEPTH0), .DEPTH_STEP(DEPTH_STEP), .FISH_SPEED(FISH_SPEED), .SINK_STEP(SINK_STEP),
        .ROD_STEP(ROD_STEP), .REEL_STEP(REEL_STEP), .HIT_W(HIT_W), .HIT_H(HIT_H), .REEL_W(REEL_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: game state as plain integers.
    int m_state, m_level, m_score, m_hx, m_hy, m_fx, m_fy, m_slack;

    function automatic int m_depth(input int lv);
        return DEPTH0 - lv * DEPTH_STEP;
    endfunction

    function automatic bit m_hit();
        int w, h, d;
        w = HIT_W >> m_level; if (w < 1) w = 1;
        h = HIT_H >> m_level; if (h < 1) h = 1;
        d = m_hy - m_fy; if (d < 0) d = -d;
        return (m_fx <= m_hx) && (m_hx <= m_fx + w) && (d <= h);
    endfunction

    function automatic void m_reset();
        m_state = int'(ST_FISH); m_level = 0; m_score = 0; m_hx = 450;
        m_hy = SURFACE_Y; m_fx = RIGHT_X; m_fy = DEPTH0; m_slack = 0;
    endfunction

    function automatic void m_step(input bit t, input bit l, input bit r, input bit g, input int reel);
        int n, pull;
        if (!t) return;
        n = reel >> (REEL_W - 4);
        pull = (n > 9) ? 2 * REEL_STEP : ((n == 9) ? REEL_STEP : 0);
        if (m_state == int'(ST_FISH)) begin
            if (g && m_hit()) begin
                m_state = int'(ST_CATCH);
                m_slack = 0;
            end else begin
                m_fx = (m_fx < LEFT_X + FISH_SPEED) ? RIGHT_X : m_fx - FISH_SPEED;
                m_fy = m_depth(m_level);
                m_hy = (m_hy + SINK_STEP > m_fy) ? m_fy : m_hy + SINK_STEP;
                if (r)      m_hx = (m_hx + ROD_STEP > RIGHT_X) ? RIGHT_X : m_hx + ROD_STEP;
                else if (l) m_hx = (m_hx - ROD_STEP < LEFT_X) ? LEFT_X : m_hx - ROD_STEP;
            end
        end else if (m_state == int'(ST_CATCH)) begin
            if (m_fy < SURFACE_Y) begin
                m_score = (m_score < 255) ? m_score + 1 : 255;
                m_slack = 0;
                if (m_level == NUM_LEVELS - 1) begin
                    m_state = int'(ST_WIN);
                end else begin
                    m_level++;
                    m_state = int'(ST_FISH);
                    m_fx = RIGHT_X;
                    m_fy = m_depth(m_level);
                end
            end else begin
`ifdef FISH_ESCAPE_EN
                if (pull == 0) m_slack++;
                else           m_slack = 0;
                if (m_slack == 64) begin
                    m_slack = 0;
                    m_state = int'(ST_FISH);
                    m_fx = RIGHT_X;
                    m_fy = m_depth(m_level);
                    return;
                end
`endif
                m_fx = m_hx;
                m_fy = (m_fy < pull) ? 0 : m_fy - pull;
                m_hy = (m_hy < pull) ? 0 : m_hy - pull;
            end
        end else begin
            if (l || r) begin
                m_state = int'(ST_FISH);
                m_level = 0; m_score = 0;
                m_fx = RIGHT_X; m_fy = DEPTH0; m_hy = SURFACE_Y;
            end
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".hook_x"}, 32'(bus.hook_x), 32'(m_hx));
        chk({tag, ".hook_y"}, 32'(bus.hook_y), 32'(m_hy));
        chk({tag, ".fish_x"}, 32'(bus.fish_x), 32'(m_fx));
        chk({tag, ".fish_y"}, 32'(bus.fish_y), 32'(m_fy));
        chk({tag, ".level"},  32'(bus.level),  32'(m_level));
        chk({tag, ".state"},  32'(bus.state),  32'(m_state));
        chk({tag, ".win"},    32'(bus.win),    32'(m_state == int'(ST_WIN)));
        chk({tag, ".score"},  32'(bus.score),  32'(m_score));
    endtask

    // One clock: drive inputs, advance the model at the edge, compare 1 time unit later.
    task automatic step(input bit t, input bit l, input bit r, input bit g, input int reel, input string tag);
        bus.tick = t; bus.left = l; bus.right = r; bus.grab = g; bus.reel = REEL_W'(reel);
        @(posedge clk);
        m_step(t, l, r, g, reel);
        #1;
        compare_all(tag);
    endtask

    task automatic do_reset();
        bus.tick = 1'b0; bus.left = 1'b0; bus.right = 1'b0; bus.grab = 1'b0; bus.reel = '0;
        rst = 1'b1;
        m_reset();
        @(posedge clk); #1;
        compare_all("reset");
        rst = 1'b0;
    endtask

    // Wait (idle) until the model says the hook sits in the window, then grab.
    task automatic catch_fish(input string tag);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 2000 && !done; k++) begin
            if (m_state == int'(ST_FISH) && m_hit()) begin
                step(1, 0, 0, 1, 0, tag);
                done = 1'b1;
            end else begin
                step(1, 0, 0, 0, 0, tag);
            end
        end
        chk({tag, ".grab_reached"}, 32'(done), 32'd1);
        chk({tag, ".in_catch"}, 32'(bus.state), 32'(ST_CATCH));
    endtask

    // Reel at full speed until the fish lands.
    task automatic land_fish(input string tag);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 400 && !done; k++) begin
            step(1, 0, 0, 0, 9'h1E0, tag);
            if (m_state != int'(ST_CATCH)) done = 1'b1;
        end
        chk({tag, ".land_reached"}, 32'(done), 32'd1);
    endtask

    typedef struct {
        bit   t, l, r, g;
        int   reel;
        int   fx, hx, hy, st;
    } vec_t;
    vec_t vt[8];

    initial begin
        vt[0] = '{t:1, l:0, r:0, g:0, reel:0,   fx:796, hx:450, hy:110, st:0};
        vt[1] = '{t:0, l:0, r:1, g:0, reel:0,   fx:796, hx:450, hy:110, st:0};
        vt[2] = '{t:1, l:0, r:1, g:0, reel:0,   fx:794, hx:453, hy:114, st:0};
        vt[3] = '{t:1, l:1, r:0, g:0, reel:0,   fx:792, hx:450, hy:118, st:0};
        vt[4] = '{t:1, l:1, r:1, g:0, reel:0,   fx:790, hx:453, hy:122, st:0};
        vt[5] = '{t:0, l:1, r:0, g:1, reel:480, fx:790, hx:453, hy:122, st:0};
        vt[6] = '{t:1, l:0, r:0, g:1, reel:0,   fx:788, hx:453, hy:126, st:0};
        vt[7] = '{t:1, l:0, r:0, g:0, reel:0,   fx:786, hx:453, hy:130, st:0};

        // Reset values and the table of single-tick vectors.
        do_reset();
        chk("reset.win", 32'(bus.win), 32'd0);
        for (int i = 0; i < 8; i++) begin
            bus.tick = vt[i].t; bus.left = vt[i].l; bus.right = vt[i].r;
            bus.grab = vt[i].g; bus.reel = REEL_W'(vt[i].reel);
            @(posedge clk);
            m_step(vt[i].t, vt[i].l, vt[i].r, vt[i].g, vt[i].reel);
            #1;
            chk($sformatf("vec%0d.fish_x", i), 32'(bus.fish_x), 32'(vt[i].fx));
            chk($sformatf("vec%0d.hook_x", i), 32'(bus.hook_x), 32'(vt[i].hx));
            chk($sformatf("vec%0d.hook_y", i), 32'(bus.hook_y), 32'(vt[i].hy));
            chk($sformatf("vec%0d.state", i),  32'(bus.state),  32'(vt[i].st));
            chk($sformatf("vec%0d.fish_y", i), 32'(bus.fish_y), 32'd470);
        end

        // Ten idle ticks after reset.
        do_reset();
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0, "idle10");
        chk("idle10.fish_x_778", 32'(bus.fish_x), 32'd778);
        chk("idle10.hook_y_146", 32'(bus.hook_y), 32'd146);
        chk("idle10.state_fish", 32'(bus.state), 32'(ST_FISH));

        // Fish wrap at the left edge; hook sink saturates at the fish depth.
        for (int k = 0; k < 400 && m_fx != LEFT_X; k++) step(1, 0, 0, 0, 0, "swim");
        chk("swim.at_left", 32'(bus.fish_x), 32'd144);
        step(1, 0, 0, 0, 0, "wrap");
        chk("wrap.fish_x_798", 32'(bus.fish_x), 32'd798);
        chk("wrap.hook_y_sat", 32'(bus.hook_y), 32'd470);

        // Rod clamps at both edges.
        for (int k = 0; k < 150; k++) step(1, 0, 1, 0, 0, "rod_right");
        chk("rod_right.clamp", 32'(bus.hook_x), 32'd798);
        step(1, 0, 1, 0, 0, "rod_right2");
        chk("rod_right2.clamp", 32'(bus.hook_x), 32'd798);
        for (int k = 0; k < 250; k++) step(1, 1, 0, 0, 0, "rod_left");
        chk("rod_left.clamp", 32'(bus.hook_x), 32'd144);

        // Level-0 catch and reel speeds, then land.
        do_reset();
        catch_fish("catch0");
        step(1, 0, 0, 0, 9'h1E0, "reel15");
        chk("reel15.fish_y", 32'(bus.fish_y), 32'd466);
        chk("reel15.fish_x_eq_hook", 32'(bus.fish_x), 32'(bus.hook_x));
        step(1, 1, 1, 0, 9'h120, "reel9");
        chk("reel9.fish_y", 32'(bus.fish_y), 32'd464);
        chk("reel9.hook_x_ignores_buttons", 32'(bus.hook_x), 32'(m_hx));
        step(1, 0, 0, 0, 9'h100, "reel8");
        chk("reel8.fish_y", 32'(bus.fish_y), 32'd464);
        step(0, 0, 0, 0, 9'h1E0, "reel_frozen");
        chk("reel_frozen.fish_y", 32'(bus.fish_y), 32'd464);
        land_fish("land0");
        chk("land0.score", 32'(bus.score), 32'd1);
        chk("land0.level", 32'(bus.level), 32'd1);
        chk("land0.fish_y", 32'(bus.fish_y), 32'd380);
        chk("land0.fish_x", 32'(bus.fish_x), 32'd798);
        chk("land0.state", 32'(bus.state), 32'(ST_FISH));

        // Remaining levels, then WIN and restart.
        for (int lv = 1; lv < NUM_LEVELS; lv++) begin
            catch_fish($sformatf("catch%0d", lv));
            land_fish($sformatf("land%0d", lv));
        end
        chk("win.state", 32'(bus.state), 32'(ST_WIN));
        chk("win.win", 32'(bus.win), 32'd1);
        chk("win.score", 32'(bus.score), 32'd4);
        step(1, 0, 0, 1, 9'h1E0, "win_hold");
        chk("win_hold.state", 32'(bus.state), 32'(ST_WIN));
        step(1, 1, 0, 0, 0, "restart");
        chk("restart.state", 32'(bus.state), 32'(ST_FISH));
        chk("restart.level", 32'(bus.level), 32'd0);
        chk("restart.score", 32'(bus.score), 32'd0);
        chk("restart.hook_y", 32'(bus.hook_y), 32'd106);
        chk("restart.win", 32'(bus.win), 32'd0);

        // Idle reeling in CATCH: escape when enabled, otherwise stay hooked.
        do_reset();
        catch_fish("slack");
`ifdef FISH_ESCAPE_EN
        for (int k = 0; k < 63; k++) step(1, 0, 0, 0, 0, "slack_idle");
        chk("slack.still_catch", 32'(bus.state), 32'(ST_CATCH));
        step(1, 0, 0, 0, 0, "slack_escape");
        chk("escape.state", 32'(bus.state), 32'(ST_FISH));
        chk("escape.fish_x", 32'(bus.fish_x), 32'd798);
        chk("escape.level", 32'(bus.level), 32'd0);
        chk("escape.score", 32'(bus.score), 32'd0);
`else
        for (int k = 0; k < 200; k++) step(1, 0, 0, 0, 0, "slack_idle");
        chk("noescape.state", 32'(bus.state), 32'(ST_CATCH));
`endif

        // Asynchronous reset in the middle of CATCH, with tick low.
        do_reset();
        catch_fish("mid_catch");
        bus.tick = 1'b0;
        #2 rst = 1'b1;
        #1;
        m_reset();
        chk("async_rst.state", 32'(bus.state), 32'(ST_FISH));
        chk("async_rst.fish_y", 32'(bus.fish_y), 32'd470);
        chk("async_rst.hook_x", 32'(bus.hook_x), 32'd450);
        @(posedge clk); #1;
        rst = 1'b0;

        // Randomized play against the model.
        for (int k = 0; k < 3000; k++) begin
            step(($urandom % 8) != 0, ($urandom % 4) == 0, ($urandom % 4) == 0,
                 ($urandom % 3) == 0, int'($urandom_range(0, 511)), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
